// File: rtl/psec6_spi_master.sv
// psec6_spi_master: SPI mode-0 initiator for the PSEC6 configuration port
// Each request becomes one 16-bit transfer: command byte {rw, addr} followed by the data byte.
// Ports:
//   clk, rstn            system clock, synchronous active-low reset
//   start, rw, addr,     request pulse (accepted when busy=0) with its operands,
//   wdata                sampled with start
//   busy                 transfer or inter-transfer gap in progress
//   done                 one-cycle pulse as cs drops; rdata/poci_err valid from then
//   rdata, poci_err      captured data byte, and a flag for any 1 seen on poci during the command byte
//   spi_clk, cs, pico    SPI clock (idle low), active-high chip select, controller data out
//   poci                 peripheral data in
module psec6_spi_master #(
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       poci_err,
    output logic       spi_clk,
    output logic       cs,
    output logic       pico,
    input  logic       poci
);
    typedef enum logic [1:0] {IDLE, SHIFT, TAIL, GAP} state_t;
    localparam logic [7:0] HMAX = 8'(CLK_DIV - 1);
    localparam logic [7:0] GMAX = 8'(CS_GAP - 1);
    state_t      state_q, state_d;
    logic [15:0] tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic        err_q, err_d;
    logic [3:0]  bit_q, bit_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        sclk_q, sclk_d;
    logic        cs_q, cs_d;
    logic        pico_q, pico_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        perr_q, perr_d;
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        err_d   = err_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        pico_d  = pico_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;
        perr_d  = perr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    tx_d    = {rw, addr, rw ? wdata : 8'h00};
                    pico_d  = rw;
                    cs_d    = 1'b1;
                    sclk_d  = 1'b0;
                    busy_d  = 1'b1;
                    bit_d   = 4'd15;
                    cnt_d   = 8'd0;
                    rx_d    = 8'h00;
                    err_d   = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == HMAX) begin
                    cnt_d  = 8'd0;
                    sclk_d = !sclk_q;
                    if (!sclk_q) begin
                        // rising edge: bit_q[3] set means we are still in the command byte
                        if (bit_q[3]) err_d = err_q | poci;
                        else rx_d = {rx_q[6:0], poci};
                    end else if (bit_q == 4'd0) begin
                        state_d = TAIL;
                    end else begin
                        bit_d  = bit_q - 4'd1;
                        tx_d   = {tx_q[14:0], 1'b0};
                        pico_d = tx_q[14];
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            TAIL: begin
                if (cnt_q == HMAX) begin
                    cnt_d   = 8'd0;
                    cs_d    = 1'b0;
                    pico_d  = 1'b0;
                    done_d  = 1'b1;
                    rdata_d = rx_q;
                    perr_d  = err_q;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            GAP: begin
                if (cnt_q == GMAX) begin
                    cnt_d   = 8'd0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            tx_q    <= 16'h0000;
            rx_q    <= 8'h00;
            err_q   <= 1'b0;
            bit_q   <= 4'd0;
            cnt_q   <= 8'd0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b0;
            pico_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= 8'h00;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            err_q   <= err_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            pico_q  <= pico_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            perr_q  <= perr_d;
        end
    end
    assign busy     = busy_q;
    assign done     = done_q;
    assign rdata    = rdata_q;
    assign poci_err = perr_q;
    assign spi_clk  = sclk_q;
    assign cs       = cs_q;
    assign pico     = pico_q;
endmodule
